// File: rtl/vx_decode_sched.sv
// Per-warp decoded-instruction queues feeding a round-robin issue selector.
// A stalled selection is held (locked) until it fires so the issue stage sees a stable offer.
module vx_decode_sched #(
   parameter int NUM_WARPS = 4,
   parameter int DEPTH     = 2,
   parameter int DATAW     = 64,
   localparam int WB       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 valid_in,
   input  logic [WB-1:0]        wid_in,
   input  logic [DATAW-1:0]     data_in,
   output logic                 ready_in,
   output logic                 valid_out,
   output logic [WB-1:0]        wid_out,
   output logic [DATAW-1:0]     data_out,
   input  logic                 ready_out,
   output logic [NUM_WARPS-1:0] empty_mask
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [DATAW-1:0]     mem_q   [NUM_WARPS][DEPTH];
   logic [PW-1:0]        head_q  [NUM_WARPS];
   logic [PW-1:0]        head_d  [NUM_WARPS];
   logic [PW-1:0]        tail_q  [NUM_WARPS];
   logic [PW-1:0]        tail_d  [NUM_WARPS];
   logic [CW-1:0]        count_q [NUM_WARPS];
   logic [CW-1:0]        count_d [NUM_WARPS];
   logic [WB-1:0]        rrPtr_q, rrPtr_d;
   logic [WB-1:0]        lockWid_q, lockWid_d;
   logic                 lock_q, lock_d;
   logic [WB-1:0]        selWid;
   logic                 anyFound;
   logic                 push, fire;
   logic [NUM_WARPS-1:0] pushVec, popVec;

   always_comb begin
      for (int w = 0; w < NUM_WARPS; w++) begin
         empty_mask[w] = (count_q[w] == '0);
      end
      ready_in = (count_q[wid_in] != CW'(DEPTH));
      push     = valid_in & ready_in;
   end

   // Scan from rrPtr upward with wrap; a held lock overrides the scan.
   always_comb begin
      selWid   = rrPtr_q;
      anyFound = 1'b0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         if (!anyFound && !empty_mask[rrPtr_q + WB'(i)]) begin
            selWid   = rrPtr_q + WB'(i);
            anyFound = 1'b1;
         end
      end
      if (lock_q) begin
         selWid = lockWid_q;
      end
      valid_out = lock_q | anyFound;
      wid_out   = selWid;
      data_out  = mem_q[selWid][head_q[selWid]];
      fire      = valid_out & ready_out;
   end

   always_comb begin
      for (int w = 0; w < NUM_WARPS; w++) begin
         pushVec[w] = push && (wid_in == WB'(w));
         popVec[w]  = fire && (selWid == WB'(w));
         head_d[w]  = popVec[w]  ? head_q[w] + PW'(1) : head_q[w];
         tail_d[w]  = pushVec[w] ? tail_q[w] + PW'(1) : tail_q[w];
         count_d[w] = count_q[w];
         if (pushVec[w] && !popVec[w]) begin
            count_d[w] = count_q[w] + CW'(1);
         end else if (!pushVec[w] && popVec[w]) begin
            count_d[w] = count_q[w] - CW'(1);
         end
      end
      rrPtr_d   = fire ? selWid + WB'(1) : rrPtr_q;
      lock_d    = lock_q;
      lockWid_d = lockWid_q;
      if (fire) begin
         lock_d = 1'b0;
      end else if (valid_out) begin
         lock_d    = 1'b1;
         lockWid_d = selWid;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q    <= '{default: '0};
         tail_q    <= '{default: '0};
         count_q   <= '{default: '0};
         rrPtr_q   <= '0;
         lock_q    <= 1'b0;
         lockWid_q <= '0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         rrPtr_q   <= rrPtr_d;
         lock_q    <= lock_d;
         lockWid_q <= lockWid_d;
      end
   end

   // Payload storage needs no reset: pointers and counts define what is live.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem_q[wid_in][tail_q[wid_in]] <= data_in;
      end
   end
endmodule

// File: tb/tb_vx_decode_sched.sv
// Bench for vx_decode_sched: directed scenarios then random traffic,
// all compared against a queue-based reference of the scheduling rules.
module tb_vx_decode_sched;
   localparam int NW = 4;
   localparam int D  = 2;

   logic          clk;
   logic          reset;
   logic          valid_in;
   logic [1:0]    wid_in;
   logic [63:0]   data_in;
   logic          ready_in;
   logic          valid_out;
   logic [1:0]    wid_out;
   logic [63:0]   data_out;
   logic          ready_out;
   logic [NW-1:0] empty_mask;

   logic [63:0] mq [NW][$];
   int          mRr;
   bit          mHeld;
   int          mHeldW;
   int          compared;
   int          mismatched;

   vx_decode_sched #(.NUM_WARPS(NW), .DEPTH(D), .DATAW(64)) dut (
      .clk        (clk),
      .reset      (reset),
      .valid_in   (valid_in),
      .wid_in     (wid_in),
      .data_in    (data_in),
      .ready_in   (ready_in),
      .valid_out  (valid_out),
      .wid_out    (wid_out),
      .data_out   (data_out),
      .ready_out  (ready_out),
      .empty_mask (empty_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Warp the reference would offer now, or -1 when nothing is offered.
   function automatic int modelSel();
      if (mHeld) return mHeldW;
      for (int i = 0; i < NW; i++) begin
         if (mq[(mRr + i) % NW].size() > 0) return (mRr + i) % NW;
      end
      return -1;
   endfunction

   task automatic modelReset();
      for (int k = 0; k < NW; k++) mq[k].delete();
      mRr    = 0;
      mHeld  = 1'b0;
      mHeldW = 0;
   endtask

   // Called at a falling edge: drive, check pre-edge outputs, advance model, cross one rising edge.
   task automatic applyStimulus(input bit rst, input bit v, input int w, input logic [63:0] d, input bit ro);
      int          sel;
      bit          mValid;
      bit          acc;
      logic [3:0]  expMask;
      logic [63:0] popped;
      reset     = rst;
      valid_in  = v;
      wid_in    = w[1:0];
      data_in   = d;
      ready_out = ro;
      #1;
      sel    = modelSel();
      mValid = (sel >= 0);
      for (int k = 0; k < NW; k++) expMask[k] = (mq[k].size() == 0);
      checkOutput("ready_in", ready_in, mq[w].size() != D);
      checkOutput("valid_out", valid_out, mValid);
      checkOutput("empty_mask", empty_mask, expMask);
      if (mValid) begin
         checkOutput("wid_out", wid_out, sel);
         checkOutput("data_out", data_out, mq[sel][0]);
      end
      if (rst) begin
         modelReset();
      end else begin
         acc = v && (mq[w].size() != D);
         if (mValid && ro) begin
            popped = mq[sel].pop_front();
            mRr    = (sel + 1) % NW;
            mHeld  = 1'b0;
         end else if (mValid) begin
            mHeld  = 1'b1;
            mHeldW = sel;
         end
         if (acc) mq[w].push_back(d);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      modelReset();
      reset     = 1'b1;
      valid_in  = 1'b0;
      wid_in    = '0;
      data_in   = '0;
      ready_out = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset state and single push with immediate issue.
      applyStimulus(1, 0, 0, 64'h0, 0);
      applyStimulus(0, 1, 2, 64'hA5, 1);
      checkOutput("r030_valid", valid_out, 1);
      checkOutput("r030_wid", wid_out, 2);
      checkOutput("r030_data", data_out, 64'hA5);
      applyStimulus(0, 0, 0, 64'h0, 1);
      checkOutput("r030_idle", valid_out, 0);
      checkOutput("r030_mask", empty_mask, 4'b1111);

      // Overfill warp 1.
      applyStimulus(1, 0, 0, 64'h0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 64'h100 + 64'(i), 0);
      checkOutput("r031_mask", empty_mask, 4'b1101);
      checkOutput("r031_ready", ready_in, 0);

      // Round-robin across warps 0, 1, 3.
      applyStimulus(1, 0, 0, 64'h0, 0);
      applyStimulus(0, 1, 0, 64'h200, 0);
      applyStimulus(0, 1, 1, 64'h201, 0);
      applyStimulus(0, 1, 3, 64'h203, 0);
      checkOutput("r032_first", wid_out, 0);
      applyStimulus(0, 0, 0, 64'h0, 1);
      checkOutput("r032_second", wid_out, 1);
      applyStimulus(0, 0, 0, 64'h0, 1);
      checkOutput("r032_third", wid_out, 3);
      applyStimulus(0, 0, 0, 64'h0, 1);
      checkOutput("r032_drained", valid_out, 0);

      // Held selection ignores a newly eligible lower warp.
      applyStimulus(1, 0, 0, 64'h0, 0);
      applyStimulus(0, 1, 2, 64'h302, 0);
      applyStimulus(0, 1, 0, 64'h300, 0);
      checkOutput("r033_hold1", wid_out, 2);
      applyStimulus(0, 0, 0, 64'h0, 0);
      checkOutput("r033_hold2", wid_out, 2);
      applyStimulus(0, 0, 0, 64'h0, 1);
      checkOutput("r033_next", wid_out, 0);
      checkOutput("r033_data", data_out, 64'h300);

      // Simultaneous push and pop on warp 0.
      applyStimulus(1, 0, 0, 64'h0, 0);
      applyStimulus(0, 1, 0, 64'h11, 0);
      applyStimulus(0, 1, 0, 64'h22, 1);
      checkOutput("r034_valid", valid_out, 1);
      checkOutput("r034_data", data_out, 64'h22);
      checkOutput("r034_mask", empty_mask, 4'b1110);

      // Reset flushes a full warp and drops the concurrent push.
      applyStimulus(1, 0, 0, 64'h0, 0);
      applyStimulus(0, 1, 3, 64'h31, 0);
      applyStimulus(0, 1, 3, 64'h32, 0);
      applyStimulus(1, 1, 3, 64'h33, 0);
      checkOutput("r035_valid", valid_out, 0);
      checkOutput("r035_mask", empty_mask, 4'b1111);
      checkOutput("r035_ready", ready_in, 1);

      // Random traffic.
      for (int n = 0; n < 800; n++) begin
         applyStimulus(($urandom % 100) == 0, ($urandom % 4) != 0, int'($urandom % NW),
                       {$urandom, $urandom}, ($urandom % 3) != 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
